sprite_motion_sequencer: RTL and testbench
==========================================

Name: sprite_motion_sequencer

Overview:
- Moves the target and torpedo sprites once per video frame, using one time-shared X/Y step adder pair.
- Loads start positions on the write strobes from the game master FSM.
- Produces the per-sprite on-screen flags that the game master FSM uses for end-of-game detection.
- Sits between the game master FSM, the frame-tick source and the sprite display datapath.

Parameters:
- X_WIDTH, 10, width of X position registers.
- Y_WIDTH, 10, width of Y position registers.
- D_WIDTH, 4, width of signed per-frame velocity (two's complement).
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- SPRITE_W, 8, sprite box width used for the on-screen test.
- SPRITE_H, 8, sprite box height used for the on-screen test.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- freeze  in  1  level; suppresses motion, writes still accepted
- tgt_write  in  1  load target position and velocity
- tgt_x_in  in  X_WIDTH  target start X
- tgt_y_in  in  Y_WIDTH  target start Y
- tgt_dx  in  D_WIDTH  target signed X step
- tgt_dy  in  D_WIDTH  target signed Y step
- trp_write  in  1  load torpedo position and velocity
- trp_x_in, trp_y_in, trp_dx, trp_dy  in  as for target  torpedo equivalents
- tgt_x, tgt_y  out  X_WIDTH, Y_WIDTH  target position (registered)
- trp_x, trp_y  out  X_WIDTH, Y_WIDTH  torpedo position (registered)
- tgt_on_screen  out  1  target box fully inside screen (registered)
- trp_on_screen  out  1  torpedo box fully inside screen (registered)
- update_done  out  1  one-cycle pulse after both sprites are stepped
- overrun  out  1  sticky; frame tick lost

Behaviour:
- Reset: all positions 0, velocities 0, on_screen 0, update_done 0, overrun 0, pending 0, state IDLE. Reset is accepted in any state; an in-progress update is abandoned.
- One-hot FSM with states IDLE, UPD_TGT, UPD_TRP, DONE.
- IDLE -> UPD_TGT when (frame_tick | pending) & !freeze, and clears pending. Otherwise stays in IDLE.
- UPD_TGT -> UPD_TRP -> DONE -> IDLE, unconditionally, one cycle each.
- Latency for a tick in cycle T sampled in IDLE:
  - tgt_x/tgt_y/tgt_on_screen change at T+2.
  - trp_* change at T+3.
  - update_done is high during cycle T+3 (state DONE).
- Step arithmetic: new_x = x + sign_extend(dx) mod 2^X_WIDTH; Y identical. Wrap-around is intentional, so a negative step from 0 gives 2^X_WIDTH-1 and the sprite reads as off-screen.
- Shared adder: in UPD_TGT the adder operands are the target registers; in UPD_TRP they are the torpedo registers. There is exactly one X adder and one Y adder.
- on_screen = (x + SPRITE_W <= SCREEN_W) & (y + SPRITE_H <= SCREEN_H). Compare at X_WIDTH+1 / Y_WIDTH+1 bits so there is no overflow.
- on_screen is recomputed whenever the position register loads, by write or by step.
- Write: xxx_write loads position and velocity on the next edge in any state.
  - Write beats step: a write in the same cycle as that sprite's UPD state loads the write values, and that sprite's step is skipped for the frame.
  - The other sprite's step is unaffected.
- Simultaneous tgt_write and trp_write: both load.
- frame_tick while not in IDLE, or while freeze is high: sets pending.
- frame_tick while pending is already 1: sets overrun, sticky until reset. pending stays 1, so at most one queued tick.
- freeze rising mid-update: the current update sequence completes. A pending tick is held until freeze drops.

Decomposition:
- Shared package holds the state encoding constants (STATE_IDLE, STATE_UPD_TGT, STATE_UPD_TRP, STATE_DONE indices) and the default screen/sprite dimension constants shared with the display datapath.
- One natural sub-module: sprite_step_adder. It is combinational: position + sign-extended step with wrap, plus the on-screen compare. It is instantiated once for X/Y and time-shared by the sequencer.

Test Plan:
- Reset mid-update: assert reset during UPD_TRP -> all outputs 0, state IDLE, next tick gives a normal sequence.
- Basic step: tgt_write x=100,y=200,dx=+3,dy=-2; tick at T -> tgt=(103,198) at T+2, update_done at T+3, trp unchanged (0,0).
- Wrap and off-screen: trp_write x=2,y=10,dx=-4,dy=0; tick -> trp_x=1022, trp_on_screen=0. Separately, x=632,dx=+1 -> x=633, on_screen 0 (633+8>640).
- Write beats step: tgt_write x=50 asserted in the UPD_TGT cycle -> tgt_x=50 (no step). Torpedo still stepped that frame.
- Tick queueing: tick in UPD_TGT -> pending, second sequence starts immediately after DONE. A third tick before that sequence starts -> overrun=1 and stays 1.
- Freeze: freeze=1, two ticks -> positions unchanged, overrun=1. Release freeze -> exactly one update sequence runs.

Source files
------------

// File: rtl/sprite_motion_sequencer_pkg.sv
// Shared definitions for the sprite motion sequencer and the display datapath.
//   - One-hot state bit indices and the state enum built from them.
//   - Default screen and sprite box dimensions.
//   - box_fits(): "does a box starting at pos with this size end inside limit".
package sprite_motion_sequencer_pkg;

  localparam int STATE_IDLE    = 0;
  localparam int STATE_UPD_TGT = 1;
  localparam int STATE_UPD_TRP = 2;
  localparam int STATE_DONE    = 3;
  localparam int NUM_STATES    = 4;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE    = 4'(1 << STATE_IDLE),
    ST_UPD_TGT = 4'(1 << STATE_UPD_TGT),
    ST_UPD_TRP = 4'(1 << STATE_UPD_TRP),
    ST_DONE    = 4'(1 << STATE_DONE)
  } state_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_SPRITE_W = 8;
  localparam int DEF_SPRITE_H = 8;

  // The sum is one bit wider than the operands, so it can never wrap and a
  // position near the top of its range always reads as off-screen.
  function automatic logic box_fits(input logic [31:0] pos,
                                    input logic [31:0] size,
                                    input logic [31:0] limit);
    logic [32:0] box_end;
    box_end = {1'b0, pos} + {1'b0, size};
    return box_end <= {1'b0, limit};
  endfunction

endpackage

// File: rtl/sprite_step_adder.sv
// Combinational X/Y step adder shared by both sprites.
//   cur_x/cur_y     : current position
//   step_x/step_y   : signed per-frame step (two's complement)
//   next_x/next_y   : position + sign-extended step, wrapping modulo 2^WIDTH
//   next_on_screen  : sprite box at next_x/next_y lies fully inside the screen
module sprite_step_adder
  import sprite_motion_sequencer_pkg::*;
#(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int D_WIDTH  = 4,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H
) (
  input  logic [X_WIDTH-1:0] cur_x,
  input  logic [Y_WIDTH-1:0] cur_y,
  input  logic [D_WIDTH-1:0] step_x,
  input  logic [D_WIDTH-1:0] step_y,
  output logic [X_WIDTH-1:0] next_x,
  output logic [Y_WIDTH-1:0] next_y,
  output logic               next_on_screen
);

  // Wrap-around is intentional: stepping left from 0 lands at the far end of
  // the coordinate range, which the on-screen test then rejects.
  assign next_x = cur_x + {{(X_WIDTH-D_WIDTH){step_x[D_WIDTH-1]}}, step_x};
  assign next_y = cur_y + {{(Y_WIDTH-D_WIDTH){step_y[D_WIDTH-1]}}, step_y};

  assign next_on_screen = box_fits(32'(next_x), 32'(SPRITE_W), 32'(SCREEN_W)) &
                          box_fits(32'(next_y), 32'(SPRITE_H), 32'(SCREEN_H));

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Moves the target and torpedo sprites once per frame through one shared
// X/Y step adder, loads start positions on write strobes, and flags whether
// each sprite box is fully on screen.
//   clk, reset            : clock, asynchronous active-high reset
//   frame_tick            : one-cycle frame strobe
//   freeze                : level, holds motion (writes still load)
//   tgt_write/trp_write   : load position and velocity for that sprite
//   tgt_*_in, trp_*_in    : start positions; tgt_d*/trp_d* signed steps
//   tgt_x/y, trp_x/y      : registered positions
//   tgt/trp_on_screen     : registered on-screen flags
//   update_done           : high for the single DONE cycle of a sequence
//   overrun               : sticky, a frame tick was lost
//   state_dbg             : one-hot FSM state
//
// Interface protocol: frame_tick is a fire-and-forget strobe with no ready.
// A tick that cannot start a sequence immediately (busy or frozen) is held in
// a one-deep pending slot; a tick arriving while that slot is full is dropped
// and recorded in overrun. Writes are likewise accepted unconditionally on
// the next edge and take priority over that sprite's step.
module sprite_motion_sequencer
  import sprite_motion_sequencer_pkg::*;
#(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int D_WIDTH  = 4,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  freeze,
  input  logic                  tgt_write,
  input  logic [X_WIDTH-1:0]    tgt_x_in,
  input  logic [Y_WIDTH-1:0]    tgt_y_in,
  input  logic [D_WIDTH-1:0]    tgt_dx,
  input  logic [D_WIDTH-1:0]    tgt_dy,
  input  logic                  trp_write,
  input  logic [X_WIDTH-1:0]    trp_x_in,
  input  logic [Y_WIDTH-1:0]    trp_y_in,
  input  logic [D_WIDTH-1:0]    trp_dx,
  input  logic [D_WIDTH-1:0]    trp_dy,
  output logic [X_WIDTH-1:0]    tgt_x,
  output logic [Y_WIDTH-1:0]    tgt_y,
  output logic [X_WIDTH-1:0]    trp_x,
  output logic [Y_WIDTH-1:0]    trp_y,
  output logic                  tgt_on_screen,
  output logic                  trp_on_screen,
  output logic                  update_done,
  output logic                  overrun,
  output logic [NUM_STATES-1:0] state_dbg
);

  state_e state, state_next;
  logic   start_update;
  logic   pending;

  logic [D_WIDTH-1:0] tgt_dx_q, tgt_dy_q, trp_dx_q, trp_dy_q;

  logic [X_WIDTH-1:0] op_x, step_x;
  logic [Y_WIDTH-1:0] op_y, step_y;
  logic [D_WIDTH-1:0] op_dx, op_dy;
  logic               step_on;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start_update = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((frame_tick || pending) && !freeze) begin
          state_next   = ST_UPD_TGT;
          start_update = 1'b1;
        end
      end
      ST_UPD_TGT: state_next = ST_UPD_TRP;
      ST_UPD_TRP: state_next = ST_DONE;
      default:    state_next = ST_IDLE;  // DONE, and recovery from bad codes
    endcase
  end

  assign update_done = (state == ST_DONE);
  assign state_dbg   = state;

  // ---------------- tick queue ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (start_update)    pending <= 1'b0;
      else if (frame_tick) pending <= 1'b1;
      if (frame_tick && pending) overrun <= 1'b1;
    end
  end

  // ---------------- shared adder ----------------
  always_comb begin
    op_x  = tgt_x;
    op_y  = tgt_y;
    op_dx = tgt_dx_q;
    op_dy = tgt_dy_q;
    if (state == ST_UPD_TRP) begin
      op_x  = trp_x;
      op_y  = trp_y;
      op_dx = trp_dx_q;
      op_dy = trp_dy_q;
    end
  end

  sprite_step_adder #(
    .X_WIDTH (X_WIDTH),  .Y_WIDTH (Y_WIDTH),  .D_WIDTH (D_WIDTH),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)
  ) u_step (
    .cur_x         (op_x),
    .cur_y         (op_y),
    .step_x        (op_dx),
    .step_y        (op_dy),
    .next_x        (step_x),
    .next_y        (step_y),
    .next_on_screen(step_on)
  );

  // ---------------- sprite registers ----------------
  // A write in the sprite's own update cycle wins and that frame's step is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_x         <= '0;
      tgt_y         <= '0;
      tgt_dx_q      <= '0;
      tgt_dy_q      <= '0;
      tgt_on_screen <= 1'b0;
    end else if (tgt_write) begin
      tgt_x         <= tgt_x_in;
      tgt_y         <= tgt_y_in;
      tgt_dx_q      <= tgt_dx;
      tgt_dy_q      <= tgt_dy;
      tgt_on_screen <= box_fits(32'(tgt_x_in), 32'(SPRITE_W), 32'(SCREEN_W)) &
                       box_fits(32'(tgt_y_in), 32'(SPRITE_H), 32'(SCREEN_H));
    end else if (state == ST_UPD_TGT) begin
      tgt_x         <= step_x;
      tgt_y         <= step_y;
      tgt_on_screen <= step_on;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trp_x         <= '0;
      trp_y         <= '0;
      trp_dx_q      <= '0;
      trp_dy_q      <= '0;
      trp_on_screen <= 1'b0;
    end else if (trp_write) begin
      trp_x         <= trp_x_in;
      trp_y         <= trp_y_in;
      trp_dx_q      <= trp_dx;
      trp_dy_q      <= trp_dy;
      trp_on_screen <= box_fits(32'(trp_x_in), 32'(SPRITE_W), 32'(SCREEN_W)) &
                       box_fits(32'(trp_y_in), 32'(SPRITE_H), 32'(SCREEN_H));
    end else if (state == ST_UPD_TRP) begin
      trp_x         <= step_x;
      trp_y         <= step_y;
      trp_on_screen <= step_on;
    end
  end

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Directed bench for sprite_motion_sequencer. Stimulus pushes the expected
// snapshot of both sprites into exp_q; the monitor pops one entry per
// update_done pulse and compares.
module tb_sprite_motion_sequencer;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int DW = 4;
  localparam int PW = 2*XW + 2*YW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick, freeze;
  logic          tgt_write, trp_write;
  logic [XW-1:0] tgt_x_in, trp_x_in;
  logic [YW-1:0] tgt_y_in, trp_y_in;
  logic [DW-1:0] tgt_dx, tgt_dy, trp_dx, trp_dy;
  logic [XW-1:0] tgt_x, trp_x;
  logic [YW-1:0] tgt_y, trp_y;
  logic          tgt_on_screen, trp_on_screen, update_done, overrun;
  logic [3:0]    state_dbg;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  int base;

  logic [PW-1:0] exp_q[$];

  sprite_motion_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .freeze(freeze),
    .tgt_write(tgt_write), .tgt_x_in(tgt_x_in), .tgt_y_in(tgt_y_in),
    .tgt_dx(tgt_dx), .tgt_dy(tgt_dy),
    .trp_write(trp_write), .trp_x_in(trp_x_in), .trp_y_in(trp_y_in),
    .trp_dx(trp_dx), .trp_dy(trp_dy),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .trp_x(trp_x), .trp_y(trp_y),
    .tgt_on_screen(tgt_on_screen), .trp_on_screen(trp_on_screen),
    .update_done(update_done), .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int tx, input int ty, input bit ton,
                                       input int rx, input int ry, input bit ron);
    return {XW'(tx), YW'(ty), ton, XW'(rx), YW'(ry), ron};
  endfunction

  function automatic logic [PW-1:0] snap();
    return {tgt_x, tgt_y, tgt_on_screen, trp_x, trp_y, trp_on_screen};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic do_write(input bit wt, input int tx, input int ty,
                          input logic [DW-1:0] tdx, input logic [DW-1:0] tdy,
                          input bit wr, input int rx, input int ry,
                          input logic [DW-1:0] rdx, input logic [DW-1:0] rdy);
    @(negedge clk);
    tgt_write = wt; tgt_x_in = XW'(tx); tgt_y_in = YW'(ty); tgt_dx = tdx; tgt_dy = tdy;
    trp_write = wr; trp_x_in = XW'(rx); trp_y_in = YW'(ry); trp_dx = rdx; trp_dy = rdy;
    @(negedge clk);
    tgt_write = 1'b0; trp_write = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && update_done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got update_done=1 required no frame queued");
      end else begin
        check("frame_snapshot", 64'(snap()), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; frame_tick = 1'b0; freeze = 1'b0;
    tgt_write = 1'b0; trp_write = 1'b0;
    tgt_x_in = '0; tgt_y_in = '0; tgt_dx = '0; tgt_dy = '0;
    trp_x_in = '0; trp_y_in = '0; trp_dx = '0; trp_dy = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pos",   {tgt_x, tgt_y, trp_x, trp_y}, 0);
    check("rst_on",    {tgt_on_screen, trp_on_screen}, 0);
    check("rst_done",  update_done, 0);
    check("rst_ovr",   overrun, 0);
    check("rst_state", state_dbg, 4'b0001);

    // Basic step with latency checks.
    do_write(1, 100, 200, 4'd3, 4'hE, 0, 0, 0, 4'd0, 4'd0);
    check("wr_tgt_pos", {tgt_x, tgt_y}, {10'd100, 10'd200});
    check("wr_tgt_on",  tgt_on_screen, 1);
    exp_q.push_back(pk(103, 198, 1, 0, 0, 1));
    pulse_tick();
    check("lat_t1_tgt", tgt_x, 100);
    @(negedge clk);
    check("lat_t2_tgt", {tgt_x, tgt_y}, {10'd103, 10'd198});
    check("lat_t2_trp_on", trp_on_screen, 0);
    check("lat_t2_done", update_done, 0);
    idle(4);

    // Negative step wraps X to 1022 -> off-screen.
    do_write(0, 0, 0, 4'd0, 4'd0, 1, 2, 10, 4'hC, 4'd0);
    exp_q.push_back(pk(106, 196, 1, 1022, 10, 0));
    pulse_tick();
    idle(5);

    // Right edge: 632 fits exactly, 633 does not.
    do_write(0, 0, 0, 4'd0, 4'd0, 1, 632, 10, 4'd1, 4'd0);
    check("wr_edge_on", trp_on_screen, 1);
    exp_q.push_back(pk(109, 194, 1, 633, 10, 0));
    pulse_tick();
    idle(5);

    // Write during UPD_TGT beats the target step; torpedo still steps.
    exp_q.push_back(pk(50, 60, 1, 634, 10, 0));
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    tgt_write = 1'b1; tgt_x_in = 10'd50; tgt_y_in = 10'd60; tgt_dx = 4'd1; tgt_dy = 4'd1;
    @(negedge clk); tgt_write = 1'b0;
    idle(5);

    // Tick queueing: ticks in IDLE, UPD_TGT (queued) and UPD_TRP (overrun).
    exp_q.push_back(pk(51, 61, 1, 635, 10, 0));
    exp_q.push_back(pk(52, 62, 1, 636, 10, 0));
    base = done_count;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_before", overrun, 0);
    @(negedge clk); frame_tick = 1'b0;
    check("ovr_set", overrun, 1);
    idle(10);
    check("two_frames", done_count - base, 2);
    check("ovr_sticky", overrun, 1);

    // Reset during UPD_TRP abandons the update.
    pulse_tick();
    @(negedge clk);
    check("st_upd_trp", state_dbg, 4'b0100);
    reset = 1'b1;
    #1;
    check("rst2_pos",   {tgt_x, tgt_y, trp_x, trp_y}, 0);
    check("rst2_flags", {tgt_on_screen, trp_on_screen, update_done, overrun}, 0);
    check("rst2_state", state_dbg, 4'b0001);
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(pk(0, 0, 1, 0, 0, 1));
    pulse_tick();
    idle(5);

    // Simultaneous writes, then freeze with two ticks.
    do_write(1, 10, 20, 4'd2, 4'd2, 1, 300, 400, 4'hF, 4'd5);
    check("wr_both", {tgt_x, tgt_y, trp_x, trp_y}, {10'd10, 10'd20, 10'd300, 10'd400});
    freeze = 1'b1;
    base = done_count;
    pulse_tick();
    idle(2);
    pulse_tick();
    idle(2);
    check("frz_pos",    {tgt_x, tgt_y, trp_x, trp_y}, {10'd10, 10'd20, 10'd300, 10'd400});
    check("frz_ovr",    overrun, 1);
    check("frz_nodone", done_count - base, 0);
    exp_q.push_back(pk(12, 22, 1, 299, 405, 1));
    freeze = 1'b0;
    idle(8);
    check("frz_one_seq", done_count - base, 1);

    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
